// File: rtl/toy_fetch_mem_responder.sv
// toy_fetch_mem_responder: fixed-latency instruction-line responder with credit-bounded response FIFO
module toy_fetch_mem_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int FETCH_SB_WIDTH = 10,
  parameter int MEM_DEPTH      = 1024,
  parameter int READ_LATENCY   = 2,
  parameter int RESP_DEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            mem_req_vld,
  output logic                            mem_req_rdy,
  input  logic [ADDR_WIDTH-1:0]           mem_req_addr,
  input  logic [FETCH_SB_WIDTH-1:0]       mem_req_sideband,
  output logic                            mem_ack_vld,
  input  logic                            mem_ack_rdy,
  output logic [DATA_WIDTH-1:0]           mem_ack_data,
  output logic [FETCH_SB_WIDTH-1:0]       mem_ack_sideband,
  input  logic                            init_wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0]    init_wr_addr,
  input  logic [DATA_WIDTH-1:0]           init_wr_data,
  output logic [$clog2(RESP_DEPTH):0]     outstanding_cnt
);
  localparam int IW  = $clog2(MEM_DEPTH);
  localparam int OFF = $clog2(DATA_WIDTH/8);
  localparam int PW  = $clog2(RESP_DEPTH);
  localparam int CW  = PW + 1;
  logic [DATA_WIDTH-1:0]     mem_q [MEM_DEPTH];
  logic [READ_LATENCY-1:0]   pv_q;
  logic [DATA_WIDTH-1:0]     pd_q [READ_LATENCY];
  logic [FETCH_SB_WIDTH-1:0] ps_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]     fd_q [RESP_DEPTH];
  logic [FETCH_SB_WIDTH-1:0] fs_q [RESP_DEPTH];
  logic [PW-1:0]             wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]             fc_q, fc_d, oc_q, oc_d;
  logic                      acc, push, pop;
  logic                      unused_addr;
  assign unused_addr      = ^mem_req_addr;
  assign mem_req_rdy      = oc_q < CW'(RESP_DEPTH);
  assign acc              = mem_req_vld & mem_req_rdy;
  assign push             = pv_q[READ_LATENCY-1];
  assign mem_ack_vld      = fc_q != '0;
  assign pop              = mem_ack_vld & mem_ack_rdy;
  assign mem_ack_data     = mem_ack_vld ? fd_q[rd_q] : '0;
  assign mem_ack_sideband = mem_ack_vld ? fs_q[rd_q] : '0;
  assign outstanding_cnt  = oc_q;
  always_comb begin
    wr_d = push ? (wr_q == PW'(RESP_DEPTH-1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? (rd_q == PW'(RESP_DEPTH-1) ? '0 : rd_q + 1'b1) : rd_q;
    fc_d = fc_q + CW'(push) - CW'(pop);
    oc_d = oc_q + CW'(acc) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      fc_q <= '0;
      oc_q <= '0;
    end else begin
      pv_q <= (pv_q << 1) | READ_LATENCY'(acc);
      wr_q <= wr_d;
      rd_q <= rd_d;
      fc_q <= fc_d;
      oc_q <= oc_d;
    end
  end
  // stage 0 samples the array on accept, so a same-edge preload write is seen only by later reads
  always_ff @(posedge clk) begin
    if (init_wr_en) mem_q[init_wr_addr] <= init_wr_data;
    pd_q[0] <= mem_q[mem_req_addr[OFF +: IW]];
    ps_q[0] <= mem_req_sideband;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pd_q[i] <= pd_q[i-1];
      ps_q[i] <= ps_q[i-1];
    end
    if (push) begin
      fd_q[wr_q] <= pd_q[READ_LATENCY-1];
      fs_q[wr_q] <= ps_q[READ_LATENCY-1];
    end
  end
endmodule
